// File: rtl/rtc_port_source.sv
// Real-time clock/calendar on the CPU I/O port bus: 1 Hz counting, port reads with tear-free shadow, presets.
// Optional alarm (ports 6-8, alarm_irq) is built when RTC_ALARM_EN is defined.
module rtc_port_source #(
  parameter int data_size  = 16,
  parameter int RESET_YEAR = 2000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 cs,
  input  logic [3:0]           op,
  input  logic [data_size-1:0] port,
  input  logic [data_size-1:0] data,
  output logic [data_size-1:0] result,
  output logic                 valid
`ifdef RTC_ALARM_EN
  ,
  output logic                 alarm_irq
`endif
);

  typedef logic [data_size-1:0] fld_t;

  localparam logic [3:0] OP_RD = 4'b0010;
  localparam logic [3:0] OP_WR = 4'b0011;

  function automatic logic is_leap(input fld_t y);
    logic [31:0] yy;
    yy = 32'(y);
    return ((yy % 32'd4) == 32'd0) &&
           (((yy % 32'd100) != 32'd0) || ((yy % 32'd400) == 32'd0));
  endfunction

  function automatic fld_t mlen(input fld_t m, input fld_t y);
    if (m == fld_t'(2))
      return is_leap(y) ? fld_t'(29) : fld_t'(28);
    else if (m == fld_t'(4) || m == fld_t'(6) || m == fld_t'(9) || m == fld_t'(11))
      return fld_t'(30);
    else
      return fld_t'(31);
  endfunction

  // Out-of-range preset values collapse to the field minimum.
  function automatic fld_t clamp(input fld_t v, input fld_t lo, input fld_t hi);
    return (v < lo || v > hi) ? lo : v;
  endfunction

  fld_t sec, min, hour, day, month, year;
  fld_t sh_min, sh_hour, sh_day, sh_month, sh_year;
  fld_t n_sec, n_min, n_hour, n_day, n_month, n_year;
  fld_t rd_data;
  logic tick_pend;
  logic rd, wr, inc;
  logic c_sec, c_min, c_hour, c_day, c_month;

`ifdef RTC_ALARM_EN
  fld_t al_hour, al_min, al_sec;
  logic inc_p1;
`endif

  assign rd  = cs && (op == OP_RD);
  assign wr  = cs && (op == OP_WR);
  assign inc = !wr && (tick || tick_pend);

  // Ripple carry through all fields within one cycle.
  always_comb begin
    c_sec   = sec >= fld_t'(59);
    c_min   = c_sec && (min >= fld_t'(59));
    c_hour  = c_min && (hour >= fld_t'(23));
    c_day   = c_hour && (day >= mlen(month, year));
    c_month = c_day && (month >= fld_t'(12));
    n_sec   = c_sec ? '0 : sec + fld_t'(1);
    n_min   = c_sec ? ((min >= fld_t'(59)) ? '0 : min + fld_t'(1)) : min;
    n_hour  = c_min ? ((hour >= fld_t'(23)) ? '0 : hour + fld_t'(1)) : hour;
    n_day   = c_hour ? ((day >= mlen(month, year)) ? fld_t'(1) : day + fld_t'(1)) : day;
    n_month = c_day ? ((month >= fld_t'(12)) ? fld_t'(1) : month + fld_t'(1)) : month;
    n_year  = c_month ? year + fld_t'(1) : year;
  end

  always_comb begin
    rd_data = '0;
    if (port == fld_t'(0))      rd_data = sec;
    else if (port == fld_t'(1)) rd_data = sh_min;
    else if (port == fld_t'(2)) rd_data = sh_hour;
    else if (port == fld_t'(3)) rd_data = sh_day;
    else if (port == fld_t'(4)) rd_data = sh_month;
    else if (port == fld_t'(5)) rd_data = sh_year;
`ifdef RTC_ALARM_EN
    else if (port == fld_t'(6)) rd_data = al_hour;
    else if (port == fld_t'(7)) rd_data = al_min;
    else if (port == fld_t'(8)) rd_data = al_sec;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
      day       <= fld_t'(1);
      month     <= fld_t'(1);
      year      <= fld_t'(RESET_YEAR);
      sh_min    <= '0;
      sh_hour   <= '0;
      sh_day    <= fld_t'(1);
      sh_month  <= fld_t'(1);
      sh_year   <= fld_t'(RESET_YEAR);
      result    <= '0;
      valid     <= 1'b0;
      tick_pend <= 1'b0;
    end else begin
      valid <= 1'b0;
      // Read sees pre-increment values; port 0 snapshots the calendar.
      if (rd) begin
        result <= rd_data;
        valid  <= 1'b1;
        if (port == fld_t'(0)) begin
          sh_min   <= min;
          sh_hour  <= hour;
          sh_day   <= day;
          sh_month <= month;
          sh_year  <= year;
        end
      end
      if (wr) begin
        result    <= '0;
        tick_pend <= tick || tick_pend;
        if (port == fld_t'(0))      sec   <= clamp(data, '0, fld_t'(59));
        else if (port == fld_t'(1)) min   <= clamp(data, '0, fld_t'(59));
        else if (port == fld_t'(2)) hour  <= clamp(data, '0, fld_t'(23));
        else if (port == fld_t'(3)) day   <= clamp(data, fld_t'(1), mlen(month, year));
        else if (port == fld_t'(4)) month <= clamp(data, fld_t'(1), fld_t'(12));
        else if (port == fld_t'(5)) year  <= data;
      end else if (inc) begin
        sec       <= n_sec;
        min       <= n_min;
        hour      <= n_hour;
        day       <= n_day;
        month     <= n_month;
        year      <= n_year;
        tick_pend <= 1'b0;
      end
    end
  end

`ifdef RTC_ALARM_EN
  // Compare one cycle after an increment so the match uses the new time.
  always_ff @(posedge clk) begin
    if (rst) begin
      al_hour   <= '0;
      al_min    <= '0;
      al_sec    <= '0;
      inc_p1    <= 1'b0;
      alarm_irq <= 1'b0;
    end else begin
      inc_p1 <= inc;
      if (wr && (port == fld_t'(6) || port == fld_t'(7) || port == fld_t'(8))) begin
        alarm_irq <= 1'b0;
        if (port == fld_t'(6))      al_hour <= clamp(data, '0, fld_t'(23));
        else if (port == fld_t'(7)) al_min  <= clamp(data, '0, fld_t'(59));
        else                        al_sec  <= clamp(data, '0, fld_t'(59));
      end else if (inc_p1 && hour == al_hour && min == al_min && sec == al_sec) begin
        alarm_irq <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rtc_port_source.sv
// Scoreboard bench for rtc_port_source: reads push expected data, the monitor pops on valid.
// Alarm checks are compiled in when RTC_ALARM_EN is defined.
module tb_rtc_port_source;

  logic        clk = 1'b0;
  logic        rst, tick, cs;
  logic [3:0]  op;
  logic [15:0] port, data;
  logic [15:0] result;
  logic        valid;
`ifdef RTC_ALARM_EN
  logic        alarm_irq;
`endif

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  rtc_port_source #(.data_size(16), .RESET_YEAR(2000)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cs(cs), .op(op),
    .port(port), .data(data), .result(result), .valid(valid)
`ifdef RTC_ALARM_EN
    , .alarm_irq(alarm_irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk(e.tag, result, e.exp);
      end
    end
  end

  task automatic drive(input logic c, input logic [3:0] o, input logic [15:0] p,
                       input logic [15:0] d, input logic t);
    cs = c; op = o; port = p; data = d; tick = t;
    @(posedge clk); #1;
    cs = 1'b0; op = 4'd0; tick = 1'b0;
  endtask

  task automatic wr(input logic [15:0] p, input logic [15:0] d, input logic t = 1'b0);
    drive(1'b1, 4'b0011, p, d, t);
  endtask

  task automatic rd(input logic [15:0] p, input logic [15:0] e, input string tag);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb.push_back(s);
    drive(1'b1, 4'b0010, p, 16'd0, 1'b0);
  endtask

  task automatic tk();
    drive(1'b0, 4'd0, 16'd0, 16'd0, 1'b1);
  endtask

  task automatic set_time(input logic [15:0] y, mo, d, h, mi, s);
    wr(5, y); wr(4, mo); wr(3, d); wr(2, h); wr(1, mi); wr(0, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; cs = 1'b0; op = 4'd0; port = '0; data = '0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    rst = 1'b0;

    rd(5, 2000, "rst_year");
    rd(0, 0, "rst_sec");
    rd(3, 1, "rst_day");
    rd(4, 1, "rst_month");
    rd(2, 0, "rst_hour");

    set_time(2023, 12, 31, 23, 59, 59);
    tk();
    rd(0, 0, "ny_sec"); rd(1, 0, "ny_min"); rd(2, 0, "ny_hour");
    rd(3, 1, "ny_day"); rd(4, 1, "ny_month"); rd(5, 2024, "ny_year");

    set_time(2024, 2, 28, 23, 59, 59);
    tk();
    rd(0, 0, "leap_sec"); rd(3, 29, "leap_day"); rd(4, 2, "leap_month");

    set_time(1900, 2, 28, 23, 59, 59);
    tk();
    rd(0, 0, "c1900_sec"); rd(3, 1, "c1900_day"); rd(4, 3, "c1900_month");

    wr(1, 7); wr(0, 59);
    rd(0, 59, "tear_sec");
    tk();
    rd(1, 7, "tear_min_old");
    rd(0, 0, "tear_sec_new");
    rd(1, 8, "tear_min_new");

    wr(0, 10, 1'b1);
    rd(0, 10, "wrtick_same");
    rd(0, 11, "wrtick_next");

    wr(0, 20, 1'b1);
    wr(1, 5, 1'b1);
    rd(0, 20, "absorb_pre");
    rd(0, 21, "absorb_one");
    rd(1, 5, "absorb_min");

    wr(0, 75); wr(1, 60); wr(2, 24); wr(5, 2023); wr(4, 13);
    rd(0, 0, "oor_sec"); rd(1, 0, "oor_min"); rd(2, 0, "oor_hour"); rd(4, 1, "oor_month13");
    wr(4, 0);
    rd(0, 0, "oor_ref"); rd(4, 1, "oor_month0");
    wr(4, 4); wr(3, 31);
    rd(0, 0, "apr_ref"); rd(3, 1, "apr_day31");
    wr(3, 30);
    rd(0, 0, "apr_ref2"); rd(3, 30, "apr_day30");
    wr(2, 23); wr(1, 59); wr(0, 59);
    tk();
    rd(0, 0, "apr_roll_sec"); rd(3, 1, "apr_roll_day"); rd(4, 5, "apr_roll_month");

    set_time(16'hFFFF, 12, 31, 23, 59, 59);
    tk();
    rd(0, 0, "ywrap_sec"); rd(5, 0, "ywrap_year"); rd(4, 1, "ywrap_month");

    rd(9, 0, "bad_port");
    drive(1'b1, 4'b0000, 16'd0, 16'd30, 1'b0);
    drive(1'b0, 4'b0011, 16'd0, 16'd30, 1'b0);
    rd(0, 0, "noop_sec");

`ifdef RTC_ALARM_EN
    wr(6, 0); wr(7, 0); wr(8, 5);
    wr(2, 0); wr(1, 0); wr(0, 4);
    tk();
    chk("alarm_early", alarm_irq, 0);
    drive(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    chk("alarm_set", alarm_irq, 1);
    rd(8, 5, "alarm_sec_rd");
    chk("alarm_hold", alarm_irq, 1);
    wr(8, 5);
    chk("alarm_clr", alarm_irq, 0);
`else
    wr(6, 3);
    rd(6, 0, "noalarm_p6");
    rd(8, 0, "noalarm_p8");
`endif

    wr(0, 40, 1'b1);
    rst = 1'b1;
    drive(1'b1, 4'b0011, 16'd0, 16'd33, 1'b1);
    rst = 1'b0;
    chk("midrst_valid", valid, 0);
    rd(0, 0, "midrst_sec");
    rd(0, 0, "midrst_nopend");
    rd(5, 2000, "midrst_year");

    drive(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    drive(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
